// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and system-bus-side signal bundle for the sprite DMA arbiter.
// master: CPU/memory environment; slave: the arbiter itself.
interface oam_dma_arbiter_if #(
  parameter int ADDR_N = 16,
  parameter int DATA_N = 8
);
  logic [ADDR_N-1:0] cpu_addr;
  logic [DATA_N-1:0] cpu_wdata;
  logic              cpu_we;
  logic [DATA_N-1:0] cpu_rdata;
  logic              cpu_rdy;
  logic [ADDR_N-1:0] bus_addr;
  logic [DATA_N-1:0] bus_wdata;
  logic              bus_we;
  logic [DATA_N-1:0] bus_rdata;
  logic              dma_active;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, bus_rdata,
    input  cpu_rdata, cpu_rdy, bus_addr, bus_wdata, bus_we, dma_active
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, bus_rdata,
    output cpu_rdata, cpu_rdy, bus_addr, bus_wdata, bus_we, dma_active
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Sprite (OAM) DMA controller and CPU/system-bus arbiter for the NES core.
// Optional macro DMA_ALIGN_EN adds the parity register and the ALIGN dummy cycle.
module oam_dma_arbiter #(
  parameter int              ADDR_N   = 16,
  parameter int              DATA_N   = 8,
  parameter logic [ADDR_N-1:0] DMA_REG  = 16'h4014,
  parameter logic [ADDR_N-1:0] DMA_DEST = 16'h2004
) (
  input  logic               clk,
  input  logic               reset,
  oam_dma_arbiter_if.slave   io
);
  localparam int CNT_N = ADDR_N - DATA_N;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ALIGN = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_N-1:0]   counter_reg, counter_next;
  logic [DATA_N-1:0]  page_reg, page_next;
  logic [DATA_N-1:0]  buffer_reg, buffer_next;

  logic [ADDR_N-1:0]  bus_addr;
  logic [DATA_N-1:0]  bus_wdata;
  logic               bus_we;
  logic               cpu_rdy;
  logic               dma_active;
  logic               read_exit_direct;

`ifdef DMA_ALIGN_EN
  logic parity_reg;

  // Free-running cycle parity; READ must start on an even cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_reg <= 1'b0;
    end else begin
      parity_reg <= ~parity_reg;
    end
  end

  assign read_exit_direct = parity_reg;
`else
  assign read_exit_direct = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      counter_reg <= '0;
      page_reg    <= '0;
      buffer_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      page_reg    <= page_next;
      buffer_reg  <= buffer_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    page_next    = page_reg;
    buffer_next  = buffer_reg;
    bus_addr     = io.cpu_addr;
    bus_wdata    = io.cpu_wdata;
    bus_we       = io.cpu_we;
    cpu_rdy      = 1'b0;
    dma_active   = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        if (io.cpu_we && (io.cpu_addr == DMA_REG)) begin
          page_next    = io.cpu_wdata;
          counter_next = '0;
          state_next   = ST_HALT;
        end
      end

      ST_HALT: begin
        // Writes cannot be stalled, so only a read cycle ends the halt.
        if (!io.cpu_we) begin
          state_next = read_exit_direct ? ST_READ : ST_ALIGN;
        end
      end

`ifdef DMA_ALIGN_EN
      ST_ALIGN: begin
        bus_we     = 1'b0;
        state_next = ST_READ;
      end
`endif

      ST_READ: begin
        bus_addr    = {page_reg, counter_reg};
        bus_wdata   = buffer_reg;
        bus_we      = 1'b0;
        buffer_next = io.bus_rdata;
        state_next  = ST_WRITE;
      end

      ST_WRITE: begin
        bus_addr     = DMA_DEST;
        bus_wdata    = buffer_reg;
        bus_we       = 1'b1;
        counter_next = counter_reg + 1'b1;
        state_next   = (counter_reg == '1) ? ST_IDLE : ST_READ;
      end

      default: begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign io.cpu_rdata  = io.bus_rdata;
  assign io.cpu_rdy    = cpu_rdy;
  assign io.bus_addr   = bus_addr;
  assign io.bus_wdata  = bus_wdata;
  assign io.bus_we     = bus_we;
  assign io.dma_active = dma_active;

endmodule
